guess_checker: RTL and testbench
================================

// Module: guess_checker
// PURPOSE
//  Player-side counterpart of the target-number lookup.
//  - Collects BCD guess digits from the keypad and drives round[2:0] into the target lookup.
//  - Compares the guess with target_digit_3..1 and reports too high / too low / correct.
//  - Counts attempts and advances rounds until the game ends.
// PARAMETERS
//  NUM_ROUNDS    3  last round index; round runs 1..NUM_ROUNDS
//  MAX_ATTEMPTS  8  wrong-guess limit per round (used only with ATTEMPT_LIMIT_EN)
// PORTS
//  clk             in   1  single clock, rising edge
//  reset           in   1  synchronous, active-high
//  Max_digit       in   2  digits per number, 1..3; value 0 is treated as 1
//  digit_in        in   4  BCD digit from keypad
//  digit_valid     in   1  1-cycle pulse: digit_in valid
//  submit          in   1  1-cycle pulse: submit guess / acknowledge result
//  target_digit_1  in   4  target ones digit (from lookup)
//  target_digit_2  in   4  target tens digit
//  target_digit_3  in   4  target hundreds digit
//  round           out  3  current round, drives lookup
//  guess_digit_1   out  4  guess ones digit
//  guess_digit_2   out  4  guess tens digit
//  guess_digit_3   out  4  guess hundreds digit
//  result_valid    out  1  high while a result is shown
//  too_high        out  1  guess > target
//  too_low         out  1  guess < target
//  correct         out  1  guess == target
//  attempts        out  4  wrong+right guesses this round, saturates at 15
//  failed          out  1  attempt limit hit (0 without ATTEMPT_LIMIT_EN)
//  game_over       out  1  all rounds finished
// BEHAVIOUR
//  Reset values: round=1; guess digits=0; entry count=0; attempts=0; all flags, failed and game_over=0; state=ENTRY.
//  Reset mid-operation takes effect at the next edge from any state.
//  States:
//  - ENTRY
//    - digit_valid with digit_in<=9 and count<Max_digit: shift d3<=d2, d2<=d1, d1<=digit_in; count++.
//    - Digits >9, or extra digits beyond Max_digit, are ignored.
//    - submit with count>=1 -> CHECK; submit with count=0 is ignored.
//    - digit_valid and submit in the same cycle: submit wins, the digit is dropped.
//  - CHECK (exactly 1 cycle)
//    - Compare {g3,g2,g1} against {t3,t2,t1} as 12-bit unsigned (valid BCD orders like decimal).
//    - Register too_high/too_low/correct (exactly one set); attempts++ (saturating) -> SHOW.
//  - SHOW
//    - result_valid=1; flags held. digit_valid is ignored.
//    - On submit: clear the guess, count and flags.
//    - If correct or failed: attempts=0, failed=0; round++, or -> DONE if round==NUM_ROUNDS.
//    - Otherwise -> ENTRY with round unchanged.
//  - DONE: game_over=1; outputs frozen; leaves only on reset.
//  Latency: submit edge -> result_valid high 2 cycles later (ENTRY->CHECK->SHOW).
//  Max_digit and target inputs are sampled combinationally; they must be stable in CHECK.
// CONFIGURATION
//  ATTEMPT_LIMIT_EN defined:
//  - A wrong guess in CHECK that brings attempts to MAX_ATTEMPTS sets failed=1 alongside its flag.
//  - The SHOW acknowledge then advances the round as if the guess were correct.
//  ATTEMPT_LIMIT_EN undefined:
//  - No limit; failed is tied to 0 and MAX_ATTEMPTS is unused.
// TESTING
//  1. Reset, Max_digit=1, target 0,0,2; digit 5, submit -> 2 cycles later result_valid=1, too_high=1, attempts=1.
//  2. Same round: ack, digit 2, submit -> correct=1; ack -> round=2, attempts=0, guess=0,0,0.
//  3. Max_digit=2, target 0,5,7; digits 5,7,9,A, submit -> guess=0,5,7 (9 dropped: over Max_digit; A dropped: >9), correct=1.
//  4. Max_digit=3, round=3, target 9,9,9; guess 999, ack -> game_over=1; further submits change nothing.
//  5. submit with no digits -> stays in ENTRY, result_valid=0; digit_valid+submit in same cycle -> digit dropped.
//  6. With ATTEMPT_LIMIT_EN, MAX_ATTEMPTS=2: two wrong guesses -> failed=1 on the 2nd; ack -> round++.
//     Also: reset asserted in SHOW -> all reset values next cycle.

Source files
------------

// File: rtl/guess_checker.sv
// Player-side guess checker: collects BCD digits, compares against the target, counts attempts, advances rounds.
// Latency: submit -> result_valid after 2 cycles (ENTRY->CHECK->SHOW); no backpressure, pulses outside ENTRY/SHOW are ignored.
// Optional attempt limit enabled by defining ATTEMPT_LIMIT_EN; default build has no limit and failed stays 0.
module guess_checker #(
  parameter int NUM_ROUNDS   = 3,
  parameter int MAX_ATTEMPTS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Max_digit,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  input  logic       submit,
  input  logic [3:0] target_digit_1,
  input  logic [3:0] target_digit_2,
  input  logic [3:0] target_digit_3,
  output logic [2:0] round,
  output logic [3:0] guess_digit_1,
  output logic [3:0] guess_digit_2,
  output logic [3:0] guess_digit_3,
  output logic       result_valid,
  output logic       too_high,
  output logic       too_low,
  output logic       correct,
  output logic [3:0] attempts,
  output logic       failed,
  output logic       game_over
);

`ifdef ATTEMPT_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_ENTRY, ST_CHECK, ST_SHOW, ST_DONE} state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_round, w_round_nxt;
  logic [3:0] r_g1, r_g2, r_g3, w_g1_nxt, w_g2_nxt, w_g3_nxt;
  logic [1:0] r_count, w_count_nxt;
  logic [3:0] r_attempts, w_attempts_nxt;
  logic       r_too_high, r_too_low, r_correct, r_failed;
  logic       w_too_high_nxt, w_too_low_nxt, w_correct_nxt, w_failed_nxt;

  logic [1:0]  w_max;
  logic [11:0] w_guess, w_target;
  logic [3:0]  w_att_inc;

  // Valid BCD orders the same as decimal, so a plain 12-bit compare suffices.
  assign w_max     = (Max_digit == 2'd0) ? 2'd1 : Max_digit;
  assign w_guess   = {r_g3, r_g2, r_g1};
  assign w_target  = {target_digit_3, target_digit_2, target_digit_1};
  assign w_att_inc = (r_attempts == 4'hF) ? r_attempts : r_attempts + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_ENTRY;
      r_round    <= 3'd1;
      r_g1       <= 4'd0;
      r_g2       <= 4'd0;
      r_g3       <= 4'd0;
      r_count    <= 2'd0;
      r_attempts <= 4'd0;
      r_too_high <= 1'b0;
      r_too_low  <= 1'b0;
      r_correct  <= 1'b0;
      r_failed   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_round    <= w_round_nxt;
      r_g1       <= w_g1_nxt;
      r_g2       <= w_g2_nxt;
      r_g3       <= w_g3_nxt;
      r_count    <= w_count_nxt;
      r_attempts <= w_attempts_nxt;
      r_too_high <= w_too_high_nxt;
      r_too_low  <= w_too_low_nxt;
      r_correct  <= w_correct_nxt;
      r_failed   <= w_failed_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_round_nxt    = r_round;
    w_g1_nxt       = r_g1;
    w_g2_nxt       = r_g2;
    w_g3_nxt       = r_g3;
    w_count_nxt    = r_count;
    w_attempts_nxt = r_attempts;
    w_too_high_nxt = r_too_high;
    w_too_low_nxt  = r_too_low;
    w_correct_nxt  = r_correct;
    w_failed_nxt   = r_failed;
    case (r_state)
      ST_ENTRY: begin
        if (submit) begin
          if (r_count != 2'd0) w_state_nxt = ST_CHECK;
        end else if (digit_valid && (digit_in <= 4'd9) && (r_count < w_max)) begin
          w_g3_nxt    = r_g2;
          w_g2_nxt    = r_g1;
          w_g1_nxt    = digit_in;
          w_count_nxt = r_count + 2'd1;
        end
      end
      ST_CHECK: begin
        w_too_high_nxt = (w_guess > w_target);
        w_too_low_nxt  = (w_guess < w_target);
        w_correct_nxt  = (w_guess == w_target);
        w_attempts_nxt = w_att_inc;
        w_failed_nxt   = LIMIT_EN && (w_guess != w_target) &&
                         (w_att_inc == MAX_ATTEMPTS[3:0]);
        w_state_nxt    = ST_SHOW;
      end
      ST_SHOW: begin
        if (submit) begin
          w_g1_nxt       = 4'd0;
          w_g2_nxt       = 4'd0;
          w_g3_nxt       = 4'd0;
          w_count_nxt    = 2'd0;
          w_too_high_nxt = 1'b0;
          w_too_low_nxt  = 1'b0;
          w_correct_nxt  = 1'b0;
          w_state_nxt    = ST_ENTRY;
          // A limit failure closes the round just like a correct guess.
          if (r_correct || r_failed) begin
            w_attempts_nxt = 4'd0;
            w_failed_nxt   = 1'b0;
            if (r_round == NUM_ROUNDS[2:0]) w_state_nxt = ST_DONE;
            else                            w_round_nxt = r_round + 3'd1;
          end
        end
      end
      default: ;
    endcase
  end

  assign round         = r_round;
  assign guess_digit_1 = r_g1;
  assign guess_digit_2 = r_g2;
  assign guess_digit_3 = r_g3;
  assign result_valid  = (r_state == ST_SHOW);
  assign too_high      = r_too_high;
  assign too_low       = r_too_low;
  assign correct       = r_correct;
  assign attempts      = r_attempts;
  assign failed        = r_failed;
  assign game_over     = (r_state == ST_DONE);

endmodule

// File: tb/tb_guess_checker.sv
// Directed and random bench for guess_checker with a decimal-value transaction model.
module tb_guess_checker;
  localparam int MAXA = 3;
`ifdef ATTEMPT_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] md = 2'd1;
  logic [3:0] digit_in = 4'd0;
  logic       digit_valid = 1'b0;
  logic       submit = 1'b0;
  logic [3:0] t1 = 4'd0, t2 = 4'd0, t3 = 4'd0;
  logic [2:0] round;
  logic [3:0] guess_digit_1, guess_digit_2, guess_digit_3, attempts;
  logic       result_valid, too_high, too_low, correct, failed, game_over;

  guess_checker #(.NUM_ROUNDS(3), .MAX_ATTEMPTS(MAXA)) dut (
    .clk(clk), .reset(reset), .Max_digit(md), .digit_in(digit_in),
    .digit_valid(digit_valid), .submit(submit),
    .target_digit_1(t1), .target_digit_2(t2), .target_digit_3(t3),
    .round(round), .guess_digit_1(guess_digit_1), .guess_digit_2(guess_digit_2),
    .guess_digit_3(guess_digit_3), .result_valid(result_valid),
    .too_high(too_high), .too_low(too_low), .correct(correct),
    .attempts(attempts), .failed(failed), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int m_round, m_att;
  int m_guess[$];
  bit m_show, m_over, m_hi, m_lo, m_eq, m_failed;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gdig(input int k);
    int idx;
    idx = m_guess.size() - k;
    return (idx >= 0) ? m_guess[idx] : 0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".round"}, 32'(round), m_round);
    chk({tag, ".g1"}, 32'(guess_digit_1), gdig(1));
    chk({tag, ".g2"}, 32'(guess_digit_2), gdig(2));
    chk({tag, ".g3"}, 32'(guess_digit_3), gdig(3));
    chk({tag, ".rv"}, 32'(result_valid), m_show);
    chk({tag, ".hi"}, 32'(too_high), m_show && m_hi);
    chk({tag, ".lo"}, 32'(too_low), m_show && m_lo);
    chk({tag, ".eq"}, 32'(correct), m_show && m_eq);
    chk({tag, ".att"}, 32'(attempts), m_att);
    chk({tag, ".failed"}, 32'(failed), m_failed);
    chk({tag, ".over"}, 32'(game_over), m_over);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; digit_valid = 1'b0; submit = 1'b0;
    tick();
    reset = 1'b0;
    m_round = 1; m_att = 0; m_guess.delete();
    m_show = 0; m_over = 0; m_hi = 0; m_lo = 0; m_eq = 0; m_failed = 0;
    check_all(tag);
  endtask

  task automatic set_tgt(input int a3, input int a2, input int a1);
    t3 = 4'(a3); t2 = 4'(a2); t1 = 4'(a1);
  endtask

  // One keypad action; the model is updated at guess/acknowledge granularity.
  task automatic act(input bit dv, input int d, input bit sb, input string tag);
    int gv, tv, eff;
    digit_valid = dv; digit_in = 4'(d); submit = sb;
    tick();
    digit_valid = 1'b0; submit = 1'b0;
    eff = (md == 2'd0) ? 1 : int'(md);
    if (!m_over) begin
      if (m_show) begin
        if (sb) begin
          m_guess.delete();
          if (m_eq || m_failed) begin
            m_att = 0; m_failed = 0;
            if (m_round == 3) m_over = 1;
            else m_round++;
          end
          m_show = 0; m_hi = 0; m_lo = 0; m_eq = 0;
        end
      end else if (sb) begin
        if (m_guess.size() > 0) begin
          chk({tag, ".check_rv"}, 32'(result_valid), 0);
          tick();
          gv = gdig(3) * 100 + gdig(2) * 10 + gdig(1);
          tv = int'(t3) * 100 + int'(t2) * 10 + int'(t1);
          m_hi = gv > tv; m_lo = gv < tv; m_eq = gv == tv;
          m_att = (m_att < 15) ? m_att + 1 : 15;
          m_failed = LIM && !m_eq && (m_att == MAXA);
          m_show = 1;
        end
      end else if (dv && d <= 9 && m_guess.size() < eff) begin
        m_guess.push_back(d);
      end
    end
    check_all(tag);
  endtask

  initial begin
    int r;
    do_reset("reset");
    // Scenario 1/2: single digit, too high then correct.
    md = 2'd1; set_tgt(0, 0, 2);
    act(1, 5, 0, "s1.dig");
    act(0, 0, 1, "s1.sub");
    act(0, 0, 1, "s1.ack");
    act(1, 2, 0, "s2.dig");
    act(0, 0, 1, "s2.sub");
    act(0, 0, 1, "s2.ack");
    // Scenario 3: extra and non-BCD digits dropped.
    md = 2'd2; set_tgt(0, 5, 7);
    act(1, 5, 0, "s3.d5");
    act(1, 7, 0, "s3.d7");
    act(1, 9, 0, "s3.d9");
    act(1, 10, 0, "s3.dA");
    act(0, 0, 1, "s3.sub");
    act(0, 0, 1, "s3.ack");
    // Scenario 4: last round ends the game.
    md = 2'd3; set_tgt(9, 9, 9);
    for (int i = 0; i < 3; i++) act(1, 9, 0, "s4.dig");
    act(0, 0, 1, "s4.sub");
    act(0, 0, 1, "s4.ack");
    act(1, 4, 0, "s4.frz_dig");
    act(0, 0, 1, "s4.frz_sub");
    act(0, 0, 1, "s4.frz_sub2");
    // Scenario 5: empty submit; digit and submit together.
    do_reset("s5.reset");
    act(0, 0, 1, "s5.empty_sub");
    act(0, 0, 0, "s5.idle");
    act(1, 3, 0, "s5.dig");
    act(1, 4, 1, "s5.both");
    act(1, 6, 0, "s5.show_dig");
    act(0, 0, 1, "s5.ack");
    // Scenario 6: repeated wrong guesses (limit or saturation), then reset in SHOW.
    do_reset("s6.reset");
    md = 2'd1; set_tgt(0, 0, 9);
    for (int i = 0; i < 16; i++) begin
      act(1, 0, 0, "s6.dig");
      act(0, 0, 1, "s6.sub");
      act(0, 0, 1, "s6.ack");
    end
    do_reset("s6.reset2");
    act(1, 1, 0, "s6.dig2");
    act(0, 0, 1, "s6.sub2");
    do_reset("s6.reset_in_show");
    // Random phase.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 11));
      if (m_over) do_reset("rnd.reset_over");
      else if (r <= 4) act(1, ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 2)), 0, "rnd.dig");
      else if (r <= 7) act(0, 0, 1, "rnd.sub");
      else if (r == 8) act(1, int'($urandom_range(0, 2)), 1, "rnd.both");
      else if (r == 9) md = 2'($urandom_range(0, 3));
      else if (r == 10) set_tgt(int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      else if ($urandom_range(0, 9) == 0) do_reset("rnd.reset");
      else act(0, 0, 0, "rnd.idle");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
